// File: rtl/uart_rx_fifo.sv
// Receive-side character FIFO for a UART: first-word-fall-through storage of
// {break, data} entries with a sticky overrun flag and a fill-level interrupt.
module uart_rx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  input  logic [PAYLOAD_BITS-1:0] in_data,
  input  logic                    in_break,
  input  logic                    rd_en,
  input  logic                    flush,
  input  logic                    clr_ovr,
  input  logic [DEPTH_LOG2:0]     irq_level,
  output logic [PAYLOAD_BITS-1:0] out_data,
  output logic                    out_break,
  output logic                    out_valid,
  output logic                    full,
  output logic [DEPTH_LOG2:0]     count,
  output logic                    overrun,
  output logic                    irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [PAYLOAD_BITS:0]   mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [DEPTH_LOG2:0]     cnt;
  logic                    ovr;
  logic                    pop;
  logic                    push;
  logic                    drop;
  logic [PAYLOAD_BITS:0]   head;

  // A full FIFO still accepts a character when the same cycle frees a slot.
  always_comb begin
    pop  = rd_en && (cnt != '0);
    push = in_valid && ((cnt != DEPTH_CNT) || pop);
    drop = in_valid && !push;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovr    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovr    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
      // A fresh drop wins over a coincident clear.
      if (drop)         ovr <= 1'b1;
      else if (clr_ovr) ovr <= 1'b0;
    end
  end

  // Storage carries no reset; stale contents are masked by the count.
  always_ff @(posedge clk) begin
    if (resetn && !flush && push) mem[wr_ptr] <= {in_break, in_data};
  end

  always_comb begin
    head      = mem[rd_ptr];
    out_valid = (cnt != '0);
    full      = (cnt == DEPTH_CNT);
    count     = cnt;
    overrun   = ovr;
    irq       = ovr || ((irq_level != '0) && (cnt >= irq_level));
    out_data  = out_valid ? head[PAYLOAD_BITS-1:0] : '0;
    out_break = out_valid && head[PAYLOAD_BITS];
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_break = 1'b0;
  logic       rd_en = 1'b0;
  logic       flush = 1'b0;
  logic       clr_ovr = 1'b0;
  logic [4:0] irq_level = '0;
  logic [7:0] out_data;
  logic       out_break;
  logic       out_valid;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       irq;

  uart_rx_fifo #(.PAYLOAD_BITS(8), .DEPTH_LOG2(4)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .in_break(in_break), .rd_en(rd_en), .flush(flush), .clr_ovr(clr_ovr),
    .irq_level(irq_level), .out_data(out_data), .out_break(out_break),
    .out_valid(out_valid), .full(full), .count(count), .overrun(overrun),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO contents as a queue, sticky overrun bit, and the
  // scoreboard of entries expected to leave the DUT.
  logic [8:0] m_q[$];
  logic [8:0] exp_q[$];
  logic       m_ovr = 1'b0;

  // Expected view of the registered state visible during the current cycle.
  int         exp_cnt = 0;
  logic       exp_ovr = 1'b0;
  logic [8:0] exp_head = '0;
  logic       armed = 1'b0;
  logic [8:0] sb_e;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic b,
                     input logic r, input logic f, input logic c, input logic rn);
    bit pop_m, acc_m;
    exp_cnt  = m_q.size();
    exp_ovr  = m_ovr;
    exp_head = (m_q.size() != 0) ? m_q[0] : 9'h0;
    resetn = rn; in_valid = v; in_data = d; in_break = b;
    rd_en = r; flush = f; clr_ovr = c;
    if (!rn || f) begin
      m_q.delete();
      m_ovr = 1'b0;
    end else begin
      pop_m = r && (m_q.size() != 0);
      acc_m = v && (m_q.size() < 16 || pop_m);
      if (pop_m) exp_q.push_back(m_q.pop_front());
      if (acc_m) m_q.push_back({b, d});
      if (v && !acc_m) m_ovr = 1'b1;
      else if (c)      m_ovr = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] d);   cyc(1, d, 0, 0, 0, 0, 1); endtask
  task automatic pop();                        cyc(0, 8'h00, 0, 1, 0, 0, 1); endtask
  task automatic idle();                       cyc(0, 8'h00, 0, 0, 0, 0, 1); endtask

  // Monitor: status against the model every cycle, popped entries against the scoreboard.
  always @(negedge clk) begin
    if (armed) begin
      chk("count", 32'(count), 32'(exp_cnt));
      chk("full", 32'(full), 32'(exp_cnt == 16));
      chk("out_valid", 32'(out_valid), 32'(exp_cnt != 0));
      chk("overrun", 32'(overrun), 32'(exp_ovr));
      chk("irq", 32'(irq), 32'(exp_ovr || (irq_level != 0 && exp_cnt >= int'(irq_level))));
      chk("head", 32'({out_break, out_data}), 32'(exp_head));
      if (resetn && !flush && rd_en && out_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'({out_break, out_data}), 32'h1ff);
        end else begin
          sb_e = exp_q.pop_front();
          chk("popped", 32'({out_break, out_data}), 32'(sb_e));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    armed = 1'b1;
    idle();

    // Three characters in, three out, then empty with zeroed outputs.
    push(8'h41); push(8'h42); push(8'h43); idle();
    pop(); pop(); pop(); idle(); idle();

    // Seventeen pushes: last is dropped, overrun sticks until cleared.
    for (int i = 0; i <= 16; i++) push(8'(i));
    idle();
    for (int i = 0; i < 16; i++) pop();
    idle();
    cyc(0, 0, 0, 0, 0, 1, 1);
    idle();

    // Full FIFO with a coincident push and pop keeps the count and no overrun.
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    cyc(1, 8'hAA, 0, 1, 0, 0, 1);
    idle();
    // Drop coinciding with clear leaves overrun set.
    cyc(1, 8'hBB, 0, 0, 0, 1, 1);
    idle();
    for (int i = 0; i < 16; i++) pop();
    cyc(0, 0, 0, 0, 0, 1, 1);
    idle();

    // BREAK tag travels with its entry.
    cyc(1, 8'h00, 1, 0, 0, 0, 1);
    push(8'h55); idle();
    pop(); idle(); pop(); idle();

    // Level interrupt threshold, then disabled level source with a full FIFO.
    irq_level = 5'd4;
    push(8'h01); push(8'h02); push(8'h03); idle();
    push(8'h04); idle();
    pop(); idle();
    irq_level = 5'd0;
    for (int i = 0; i < 13; i++) push(8'h10 + 8'(i));
    idle();
    cyc(0, 0, 0, 0, 1, 0, 1);
    idle();

    // Flush outranks a same-cycle push and pop.
    for (int i = 0; i < 5; i++) push(8'h20 + 8'(i));
    cyc(1, 8'hEE, 0, 1, 1, 0, 1);
    idle();

    // Forty push/pop pairs wrap the pointers several times.
    for (int i = 0; i < 40; i++) begin
      push(8'h60 + 8'(i));
      pop();
    end
    idle();

    // Reset mid-operation discards entries and ignores coincident strobes.
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
    cyc(1, 8'h77, 0, 1, 0, 0, 0);
    idle();

    // Randomized traffic, alternating fill-heavy and drain-heavy phases.
    for (int i = 0; i < 2400; i++) begin
      logic v, b, r, f, c;
      int rd_pct;
      rd_pct = ((i / 300) % 2 == 0) ? 20 : 70;
      v = ($urandom_range(0, 99) < 55);
      b = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 99) < rd_pct);
      f = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 63) == 0) irq_level = 5'($urandom_range(0, 16));
      cyc(v, 8'($urandom), b, r, f, c, 1);
    end

    for (int i = 0; i < 17; i++) pop();
    idle(); idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 8, width of each received character.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, log2 of FIFO depth (DEPTH = 2^DEPTH_LOG2 = 16).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  one-cycle strobe from UART receiver: character complete.
REQ-006 SHALL have port in_data  input  PAYLOAD_BITS  received character, qualified by in_valid.
REQ-007 SHALL have port in_break  input  1  BREAK indication, qualified by in_valid.
REQ-008 SHALL have port rd_en  input  1  CPU pop strobe, one entry per asserted cycle.
REQ-009 SHALL have port flush  input  1  discard all stored entries.
REQ-010 SHALL have port clr_ovr  input  1  clear sticky overrun flag.
REQ-011 SHALL have port irq_level  input  DEPTH_LOG2+1  fill threshold for irq; 0 disables the level source.
REQ-012 SHALL have port out_data  output  PAYLOAD_BITS  head-of-FIFO character (first-word-fall-through).
REQ-013 SHALL have port out_break  output  1  BREAK tag stored with the head entry.
REQ-014 SHALL have port out_valid  output  1  FIFO not empty.
REQ-015 SHALL have port full  output  1  count == DEPTH.
REQ-016 SHALL have port count  output  DEPTH_LOG2+1  number of stored entries, 0..DEPTH.
REQ-017 SHALL have port overrun  output  1  sticky: a character was dropped.
REQ-018 SHALL have port irq  output  1  interrupt request to CPU.

Function
REQ-019 SHALL store {in_break, in_data} per entry in a DEPTH-entry array; wr_ptr and rd_ptr DEPTH_LOG2 bits, wrap modulo DEPTH naturally.
REQ-020 SHALL accept a push when in_valid and (count < DEPTH or pop occurs in the same cycle); the entry is visible on out_* the following cycle.
REQ-021 SHALL perform a pop when rd_en and count != 0; rd_en when empty SHALL be ignored (no pointer/count change, no error flag).
REQ-022 SHALL update count: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop (including full and push into empty is push-only since empty pop is ignored).
REQ-023 SHALL, on in_valid while full with no same-cycle pop, drop the character, leave array/pointers unchanged, set overrun next cycle.
REQ-024 SHALL hold overrun until clr_ovr, flush or reset; if a new drop and clr_ovr coincide, overrun SHALL remain 1.
REQ-025 SHALL present out_data/out_break = array[rd_ptr] when out_valid, else all zeros.
REQ-026 SHALL derive out_valid, full, count, irq from registered state only (no combinational path from in_valid/rd_en to outputs).
REQ-027 SHALL drive irq = overrun OR (irq_level != 0 AND count >= irq_level).
REQ-028 SHALL, on flush, zero wr_ptr, rd_ptr, count and overrun next cycle; flush SHALL take priority over any same-cycle push, pop or drop.
REQ-029 SHALL never reorder entries; pop order equals push order.

Reset
REQ-030 SHALL, while resetn == 0 at a clock edge, zero wr_ptr, rd_ptr, count, overrun; outputs then: out_valid=0, full=0, count=0, overrun=0, irq=0, out_data=0, out_break=0.
REQ-031 SHALL not require array contents to be reset; reset mid-operation SHALL discard all entries and ignore same-cycle in_valid/rd_en.

Verification
REQ-032 Push 0x41,0x42,0x43 (no reads) -> count=3, out_data=0x41; three rd_en pulses -> 0x42, 0x43, then out_valid=0, out_data=0x00.
REQ-033 Push 17 characters 0x00..0x10 with no reads -> full=1, count=16, overrun=1, irq=1; draining yields 0x00..0x0F, 0x10 lost; clr_ovr -> overrun=0.
REQ-034 Full FIFO, in_valid=1 with rd_en=1 same cycle -> count stays 16, overrun stays 0, new char appears after the 15 older entries.
REQ-035 in_valid with in_break=1, in_data=0x00 -> out_break=1 at head; next ordinary char 0x55 -> out_break=0 after pop.
REQ-036 irq_level=4: push 3 -> irq=0; 4th push -> irq=1 next cycle; pop one -> irq=0; irq_level=0 with 16 entries and no overrun -> irq=0.
REQ-037 Push 5, then assert flush together with in_valid and rd_en -> count=0, out_valid=0, overrun=0; pointer wrap verified by 40 push/pop pairs with data intact.
